// File: rtl/angle_combination_accumulate.sv
// ---------------------------------------------------------------------------
// angle_combination_accumulate
//
// Purpose:
//   Builds the angle-combination memory as the running floating-point sum of
//   the base angles:
//     combination[0] = base[0]
//     combination[k] = combination[k-1] + base[k],  k = 1..NUM_ANGLE-1
//   The base memory is read through a registered-read port, additions are done
//   by a shared external FP adder (start/ready handshake), and every result is
//   written to the combination memory. A one-cycle done pulse follows the last
//   write so the normalization stage can start on that memory.
//
// Ports:
//   clock / reset_n                         clock, asynchronous active-low reset
//   start_angle_combination                 request a pass (sampled only in IDLE)
//   mem_base_angle_read_addr / _data_out    base memory read port (1-cycle latency)
//   mem_angle_combination_value_*           combination memory write port
//   angle_combination_add_a/_b/_start       external adder request
//   angle_combination_add_sum/_ready        external adder response
//   angle_combination_busy                  high from start accepted until done
//   angle_combination_done                  one-cycle completion pulse
// ---------------------------------------------------------------------------
module angle_combination_accumulate #(
  parameter  int EXP_LEN      = 8,
  parameter  int MANTISSA_LEN = 23,
  parameter  int NUM_ANGLE    = 22,
  localparam int W            = EXP_LEN + MANTISSA_LEN + 1,
  localparam int AW           = (NUM_ANGLE > 1) ? $clog2(NUM_ANGLE) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start_angle_combination,
  output logic [AW-1:0] mem_base_angle_read_addr,
  input  logic [W-1:0]  mem_base_angle_data_out,
  output logic [AW-1:0] mem_angle_combination_value_write_addr,
  output logic [W-1:0]  mem_angle_combination_value_data_in,
  output logic          mem_angle_combination_value_write_en,
  output logic [W-1:0]  angle_combination_add_a,
  output logic [W-1:0]  angle_combination_add_b,
  output logic          angle_combination_add_start,
  input  logic [W-1:0]  angle_combination_add_sum,
  input  logic          angle_combination_add_ready,
  output logic          angle_combination_busy,
  output logic          angle_combination_done
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_FETCH       = 3'd1;
  localparam logic [2:0] ST_LATCH       = 3'd2;
  localparam logic [2:0] ST_FIRST_WRITE = 3'd3;
  localparam logic [2:0] ST_ADD         = 3'd4;
  localparam logic [2:0] ST_ADD_WAIT    = 3'd5;
  localparam logic [2:0] ST_FINISH      = 3'd6;

  localparam logic [AW-1:0] LAST_K = AW'(NUM_ANGLE - 1);

  logic [2:0]    r_state;
  logic [AW-1:0] r_k;
  logic [W-1:0]  r_acc;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_wr_addr;
  logic [W-1:0]  r_wr_data;
  logic          r_wr_en;
  logic [W-1:0]  r_add_a;
  logic [W-1:0]  r_add_b;
  logic          r_add_start;
  logic          r_busy;
  logic          r_done;

  logic [AW-1:0] w_k_next;
  logic          w_last;

  assign w_k_next = r_k + AW'(1);
  assign w_last   = (r_k == LAST_K);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_acc       <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done    <= 1'b0;
          r_rd_addr <= '0;
          if (start_angle_combination) begin
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end

        // Registered-read memory: data for r_rd_addr appears next cycle.
        // Also retires the write strobe issued by the previous accept.
        ST_FETCH: begin
          r_wr_en <= 1'b0;
          r_state <= ST_LATCH;
        end

        ST_LATCH: begin
          if (r_k == '0) begin
            r_acc     <= mem_base_angle_data_out;
            r_wr_addr <= '0;
            r_wr_data <= mem_base_angle_data_out;
            r_wr_en   <= 1'b1;
            r_state   <= ST_FIRST_WRITE;
          end else begin
            r_add_a     <= r_acc;
            r_add_b     <= mem_base_angle_data_out;
            r_add_start <= 1'b1;
            r_state     <= ST_ADD;
          end
        end

        ST_FIRST_WRITE: begin
          r_wr_en <= 1'b0;
          if (NUM_ANGLE == 1) begin
            r_state <= ST_FINISH;
          end else begin
            r_k       <= AW'(1);
            r_rd_addr <= AW'(1);
            r_state   <= ST_FETCH;
          end
        end

        // ADD and ADD_WAIT share the accept path so that a zero-latency adder
        // (ready in the same cycle as start) is handled like a slow one.
        ST_ADD, ST_ADD_WAIT: begin
          r_add_start <= 1'b0;
          if (angle_combination_add_ready) begin
            r_acc     <= angle_combination_add_sum;
            r_wr_addr <= r_k;
            r_wr_data <= angle_combination_add_sum;
            r_wr_en   <= 1'b1;
            if (w_last) begin
              r_state <= ST_FINISH;
            end else begin
              r_k       <= w_k_next;
              r_rd_addr <= w_k_next;
              r_state   <= ST_FETCH;
            end
          end else begin
            r_state <= ST_ADD_WAIT;
          end
        end

        ST_FINISH: begin
          r_wr_en   <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_rd_addr <= '0;
          r_state   <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_base_angle_read_addr               = r_rd_addr;
  assign mem_angle_combination_value_write_addr = r_wr_addr;
  assign mem_angle_combination_value_data_in    = r_wr_data;
  assign mem_angle_combination_value_write_en   = r_wr_en;
  assign angle_combination_add_a                = r_add_a;
  assign angle_combination_add_b                = r_add_b;
  assign angle_combination_add_start            = r_add_start;
  assign angle_combination_busy                 = r_busy;
  assign angle_combination_done                 = r_done;

endmodule
